// File: rtl/inst_encoder_if.sv
// Handshake/field bundle for inst_encoder: slave is the encoder's view, master the producer/consumer view.
interface inst_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_illegal;
  logic              out_err;

  modport slave (
    input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_illegal, out_err
  );

  modport master (
    output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_illegal, out_err
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I field packer with word-address tagging; INST_ENCODER_RANGE_CHECK_EN enables immediate range/alignment flags.
// Latency 1 cycle through a register stage; a one-entry skid absorbs the word arriving during a stall.
// Backpressure: in_ready is low only while the skid holds a word; out_* hold stable until taken.
module inst_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic           clk,
  input logic           rst,
  input logic           restart,
  inst_encoder_if.slave bus
);

  typedef struct packed {
    logic [31:0] inst;
    logic        illegal;
    logic        err;
  } enc_t;

  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_BAD} fmt_t;

  logic [6:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;

  assign op  = bus.opcode;
  assign rd  = bus.rd;
  assign rs1 = bus.rs1;
  assign rs2 = bus.rs2;
  assign f3  = bus.funct3;
  assign f7  = bus.funct7;
  assign imm = bus.imm;

  fmt_t fmt;
  enc_t enc;

  always_comb begin
    fmt         = F_BAD;
    enc.inst    = 32'h0000_0013;
    enc.illegal = 1'b0;
    enc.err     = 1'b0;
    case (op)
      7'b0110111, 7'b0010111: begin
        fmt      = F_U;
        enc.inst = {imm[31:12], rd, op};
      end
      7'b1101111: begin
        fmt      = F_J;
        enc.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        fmt      = F_I;
        enc.inst = {imm[11:0], rs1, f3, rd, op};
      end
      7'b0100011: begin
        fmt      = F_S;
        enc.inst = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      7'b1100011: begin
        fmt      = F_B;
        enc.inst = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      7'b0110011: begin
        fmt      = F_R;
        enc.inst = {f7, rs2, rs1, f3, rd, op};
      end
      default: enc.illegal = 1'b1;
    endcase
`ifdef INST_ENCODER_RANGE_CHECK_EN
    // An immediate fits its field when every bit above the field's sign bit copies it.
    case (fmt)
      F_I, F_S: enc.err = !(&imm[31:11] || !(|imm[31:11]));
      F_B:      enc.err = !(&imm[31:12] || !(|imm[31:12])) || imm[0];
      F_J:      enc.err = !(&imm[31:20] || !(|imm[31:20])) || imm[0];
      F_U:      enc.err = |imm[11:0];
      default:  enc.err = 1'b0;
    endcase
`else
    enc.err = 1'b0;
`endif
  end

  logic              out_vld_q;
  enc_t              out_q;
  logic [ADDR_W-1:0] addr_q;
  logic              skid_vld;
  enc_t              skid;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_cur;
  logic              take;
  logic              out_free;
  logic              load;

  assign take     = bus.in_valid && !skid_vld;
  assign out_free = !out_vld_q || bus.out_ready;
  assign load     = out_free && (skid_vld || take);
  // restart applies to the word entering on the same edge.
  assign cnt_cur  = restart ? BASE_ADDR : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      addr_q    <= BASE_ADDR;
      skid_vld  <= 1'b0;
      skid      <= '0;
      cnt       <= BASE_ADDR;
    end else begin
      if (out_free) begin
        out_vld_q <= skid_vld || take;
        if (skid_vld) begin
          out_q    <= skid;
          skid_vld <= 1'b0;
        end else if (take) begin
          out_q <= enc;
        end
      end else if (take) begin
        skid     <= enc;
        skid_vld <= 1'b1;
      end
      if (load) begin
        addr_q <= cnt_cur;
        cnt    <= cnt_cur + ADDR_W'(4);
      end else if (restart) begin
        cnt <= BASE_ADDR;
      end
    end
  end

  assign bus.in_ready    = !skid_vld;
  assign bus.out_valid   = out_vld_q;
  assign bus.out_inst    = out_q.inst;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_err     = out_q.err;
  assign bus.out_addr    = addr_q;

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Packs decoded RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) into a 32-bit instruction word.
- Inverse of the immediate sign extender: immediate bits are scattered into the I/S/B/U/J layouts.
- Output carries an instruction-memory word address, for the program loader and for self-check benches writing instruction memory.
- Valid/ready on both sides; one register stage plus a one-entry skid buffer.

Parameters:
ADDR_W, 32, width of the output word-address counter
BASE_ADDR, 0, counter value after reset or restart; must be a multiple of 4

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
restart  input  1  synchronous reload of address counter to BASE_ADDR; pipeline contents kept
in_valid  input  1  input fields valid
in_ready  output  1  encoder can accept
opcode  input  7  instruction opcode
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field, R-type only
imm  input  32  immediate in architectural (already sign-extended) form
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts
out_inst  output  32  encoded instruction
out_addr  output  ADDR_W  address assigned to out_inst
out_illegal  output  1  opcode not supported
out_err  output  1  immediate range/alignment violation (see Optional Feature)

Behaviour:
- Reset (clk edge with rst=1): out_valid=0, out_inst=0, out_illegal=0, out_err=0, skid empty, in_ready=1, address counter=BASE_ADDR. rst overrides restart and all handshakes; a reset mid-stream drops held words without emitting them.
- Format selection by opcode:
  - U-type, 0110111 / 0010111: {imm[31:12], rd, op}
  - J-type, 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - I-type, 1100111 / 0000011 / 0010011: {imm[11:0], rs1, f3, rd, op}
  - S-type, 0100011: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B-type, 1100011: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - R-type, 0110011: {f7, rs2, rs1, f3, rd, op}
  - Any other opcode: out_inst=32'h00000013 (NOP), out_illegal=1, regardless of macro.
- Fields not used by the selected format are ignored.
- Latency: a word accepted at edge N appears on out_* after edge N (1 cycle) when the output stage is empty or draining.
- Handshake:
  - Input transfers on in_valid&in_ready; output transfers on out_valid&out_ready.
  - out_* held stable while out_valid=1 and out_ready=0.
  - in_ready = skid empty. A word arriving while the output stage is stalled goes to the skid; in_ready then drops the next cycle.
  - On the output transfer the skid word moves to the output stage. Simultaneous input acceptance and output transfer loses nothing and reorders nothing.
  - Throughput 1 word/cycle when out_ready=1.
- Address:
  - out_addr is assigned when a word enters the output stage, from a counter that advances by 4 on each such entry.
  - Counter wraps modulo 2^ADDR_W.
  - restart=1 reloads the counter to BASE_ADDR for the next entry. A word entering on the same edge gets BASE_ADDR and the counter becomes BASE_ADDR+4.

Optional Feature:
- Macro: INST_ENCODER_RANGE_CHECK_EN.
- Defined: out_err=1 when any of the following holds (word is still emitted, truncated per the layout):
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]!=0.
  - R/illegal: out_err=0.
- Undefined: out_err tied 0; silent truncation.

Test Plan:
- ADDI x1,x0,-1 (op 0010011, rd 1, rs1 0, f3 0, imm FFFFFFFF), out_ready=1 -> out_inst=FFF00093 one cycle later, out_addr=0, out_err=0.
- SW x2,8(x1) (op 0100011, rs1 1, rs2 2, f3 010, imm 8) -> 0020A423; BEQ x0,x0,-4 (imm FFFFFFFC) -> FE000EE3; JAL x1,+2048 (imm 800) -> 001000EF; back-to-back with out_addr 0,4,8.
- Backpressure: hold out_ready=0 and present 3 words. Required: in_ready=0 after 2 accepted; release out_ready; all 3 words emerge in order with addrs 0,4,8, no duplication.
- Opcode 1111111 -> out_inst=00000013, out_illegal=1. restart pulse then next word -> out_addr=BASE_ADDR. ADDR_W=4 with 5 words -> addrs 0,4,8,C,0.
- ADDI imm 00000800, with macro -> out_inst=80000093, out_err=1; without macro -> out_err=0. LUI imm 00001001, with macro -> out_err=1.
- Assert rst while out_valid=1 and the skid is full -> next cycle out_valid=0, in_ready=1; next emitted out_addr=BASE_ADDR.
